sect283k1_pt_mul_host: RTL and testbench
========================================

Name: sect283k1_pt_mul_host

Overview:
- Word-serial initiator that drives sect283k1_pt_mul: accepts a 283-bit scalar d as nine 32-bit words, pulses start, waits for done, captures x/y and streams them out as eighteen 32-bit words.
- Sits between the bus/CPU-side stream fabric and the point-multiplier core. It is the master side of the core's clr/start/d/done/x/y protocol.
- Integration ties the core's rst_n to ~rst.

Parameters:
- TimeoutCycles, 24'd1_000_000, maximum WAIT-state cycles before abort. Used only with PT_MUL_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clr  in  1  synchronous abort pulse
- in_valid  in  1  scalar word valid
- in_ready  out  1  scalar word accepted when in_valid&&in_ready
- in_data  in  32  scalar word, LSW first
- out_valid  out  1  result word valid
- out_ready  in  1  sink ready
- out_data  out  32  result word
- out_last  out  1  marks result word 17
- busy  out  1  high in START/WAIT/CAPT
- err  out  1  sticky timeout flag
- pm_clr  out  1  to core clr
- pm_start  out  1  to core start
- pm_d  out  283  to core d
- pm_done  in  1  from core done
- pm_x  in  283  from core x
- pm_y  in  283  from core y

Behaviour:
- Reset (rst=1 at posedge):
  - state=LOAD; word counter=0; scalar register=0; result registers=0; done_q=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, err=0, pm_clr=0, pm_start=0, pm_d=0.
- States: LOAD, START, WAIT, CAPT, SEND.
- LOAD:
  - in_ready=1.
  - Each transfer stores in_data into scalar bits [32k+31:32k] for word k=0..8.
  - Word 8: only in_data[26:0] is used; bits [31:27] are ignored.
  - After the word-8 transfer: go to START; counter=0.
- START:
  - Exactly one cycle with pm_start=1. pm_d holds the scalar from this cycle until the next LOAD completes.
  - Then go to WAIT.
- WAIT:
  - done_q registers pm_done every cycle in all states.
  - A rising edge (pm_done=1 && done_q=0) seen in WAIT moves the block to CAPT.
  - Edges outside WAIT are ignored.
- CAPT:
  - One cycle: latch pm_x and pm_y. This is the cycle after the edge is detected.
  - Go to SEND with counter=0.
- SEND:
  - out_valid=1.
  - Counter k=0..8 emits x[32k+31:32k]; k=9..17 emits y[32(k-9)+31:32(k-9)].
  - Words 8 and 17 are zero-extended: bits [31:27]=0.
  - out_last=1 only at k=17.
  - Counter advances only on out_valid&&out_ready. out_data and out_last stay stable while stalled.
  - After the word-17 handshake: go to LOAD, out_valid=0.
- in_ready=0 in every state except LOAD. out_valid=0 in every state except SEND.
- clr has top priority in any state:
  - Next cycle: pm_clr=1 for exactly one cycle.
  - state=LOAD, counter=0, scalar register=0, out_valid=0, err=0.
  - A transfer in the same cycle as clr is discarded.
- rst has priority over clr and does not pulse pm_clr.
- Partial scalar load (fewer than 9 words) waits indefinitely. Only clr or rst discards it.
- Back-to-back operations: the next scalar is loaded only after the SEND phase completes. There is no overlap.

Optional Feature:
- Macro: PT_MUL_TIMEOUT_EN.
- Defined:
  - A 24-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TimeoutCycles with no done edge: err=1 (sticky), pm_clr pulses for one cycle, state returns to LOAD, and no result words are emitted.
  - err clears only on clr or rst.
- Undefined: no counter; err is tied to 0; WAIT lasts indefinitely.

Test Plan:
- Generator check: load d=1 (words 0x00000001 then eight zeros), core modelled or real.
  - pm_start high for exactly one cycle.
  - out words 0..8 = 0x58492836, 0xB0C2AC24, 0x16876913, 0x23C1567A, 0x53CD265F, 0x62F188E5, 0x3F1A3B81, 0x78CA4488, 0x0503213F.
  - out words 9..17 = 0x77DD2259, 0x4E341161, 0xE4596236, 0xE8184698, 0xE87E45C0, 0x07E5426F, 0x8D90F95D, 0x0F1C9E31, 0x01CCDA38.
  - out_last only on word 17.
- Word-8 masking: load word 8 = 0xFFFFFFFF with other words 0 -> pm_d = {27'h7FFFFFF, 256'h0}.
- Backpressure: random out_ready (about 30% high) -> 18 words in order, none duplicated or dropped, data stable during stalls, in_ready=0 throughout SEND.
- Abort: clr asserted after 4 scalar words are loaded, and separately in mid-WAIT.
  - Each case: one-cycle pm_clr, in_ready=1 the next cycle, no output words.
  - A following full d=1 run yields the Gx/Gy words above.
- Done-edge filtering: pm_done held high from an earlier operation before START -> no capture until pm_done falls and then rises in WAIT; one capture per operation.
- Timeout (PT_MUL_TIMEOUT_EN, TimeoutCycles=100): pm_done tied low.
  - Exactly 100 WAIT cycles, then err=1, one pm_clr pulse, return to LOAD.
  - A subsequent clr returns err to 0.

Source files
------------

// File: rtl/sect283k1_pt_mul_host.sv
// Word-serial host for the sect283k1 point multiplier core.
// Collects a 283-bit scalar as nine 32-bit words (LSW first), starts the core,
// waits for a rising done edge, captures x/y and streams them out as eighteen
// 32-bit words (x first, LSW first).
// Optional WAIT-state watchdog enabled by defining PT_MUL_TIMEOUT_EN.
module sect283k1_pt_mul_host #(
  parameter logic [23:0] TimeoutCycles = 24'd1_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         busy,
  output logic         err,
  output logic         pm_clr,
  output logic         pm_start,
  output logic [282:0] pm_d,
  input  logic         pm_done,
  input  logic [282:0] pm_x,
  input  logic [282:0] pm_y
);

  typedef enum logic [2:0] {StLoad, StStart, StWait, StCapt, StSend} state_e;

  state_e         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [255:0]   scalar_q;   // words 0..7 while loading
  logic [282:0]   pm_d_q;     // full scalar, updated only when word 8 lands
  logic [282:0]   x_q, y_q;
  logic           done_q;
  logic           pm_clr_q;
  logic           err_q;
  logic           done_rise;
  logic           load_we;
  logic           timeout;
  logic [287:0]   res_sel;
  logic [3:0]     word_idx;
  logic [8:0]     bit_off;

  assign done_rise = pm_done && !done_q;
  assign load_we   = (state_q == StLoad) && in_valid;
  assign pm_d      = pm_d_q;
  assign pm_clr    = pm_clr_q;
  assign err       = err_q;

`ifdef PT_MUL_TIMEOUT_EN
  logic [23:0] tmo_q, tmo_d;

  // Watchdog: held at zero outside WAIT, so it restarts on every WAIT entry.
  always_comb begin
    tmo_d = tmo_q + 24'd1;
  end

  assign timeout = (state_q == StWait) && !done_rise && (tmo_d == TimeoutCycles);

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst || (state_q != StWait)) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles;
  assign timeout = 1'b0;
`endif

  // Result word select: words 0..8 from x, 9..17 from y, top word zero-extended.
  always_comb begin
    res_sel  = (cnt_q < 5'd9) ? {5'b0, x_q} : {5'b0, y_q};
    word_idx = (cnt_q < 5'd9) ? cnt_q[3:0] : 4'(cnt_q - 5'd9);
    bit_off  = {word_idx, 5'b0};
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    pm_start  = 1'b0;
    unique case (state_q)
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt_q == 5'd8) begin
            state_d = StStart;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      StStart: begin
        busy     = 1'b1;
        pm_start = 1'b1;
        state_d  = StWait;
      end
      StWait: begin
        busy = 1'b1;
        if (done_rise) begin
          state_d = StCapt;
        end else if (timeout) begin
          state_d = StLoad;
        end
      end
      StCapt: begin
        busy    = 1'b1;
        state_d = StSend;
        cnt_d   = '0;
      end
      StSend: begin
        out_valid = 1'b1;
        out_data  = res_sel[bit_off +: 32];
        out_last  = (cnt_q == 5'd17);
        if (out_ready) begin
          if (cnt_q == 5'd17) begin
            state_d = StLoad;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = StLoad;
        cnt_d   = '0;
      end
    endcase
  end

  // State, datapath registers; rst beats clr, clr beats everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StLoad;
      cnt_q    <= '0;
      scalar_q <= '0;
      pm_d_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
      pm_clr_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= pm_done;
      if (clr) begin
        state_q  <= StLoad;
        cnt_q    <= '0;
        scalar_q <= '0;
        pm_d_q   <= '0;
        err_q    <= 1'b0;
        pm_clr_q <= 1'b1;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        pm_clr_q <= timeout;
        if (timeout) begin
          err_q <= 1'b1;
        end
        if (load_we) begin
          if (cnt_q == 5'd8) begin
            pm_d_q <= {in_data[26:0], scalar_q};
          end else begin
            scalar_q[{cnt_q[2:0], 5'b0} +: 32] <= in_data;
          end
        end
        if (state_q == StCapt) begin
          x_q <= pm_x;
          y_q <= pm_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_sect283k1_pt_mul_host.sv
// Self-checking bench for sect283k1_pt_mul_host with a behavioural core model
// and a scoreboard of expected result words.
module tb_sect283k1_pt_mul_host;

`ifdef PT_MUL_TIMEOUT_EN
  localparam logic [23:0] TbTimeout = 24'd100;
`else
  localparam logic [23:0] TbTimeout = 24'd1_000_000;
`endif
  localparam int CoreLat = 30;

  localparam logic [282:0] Gx = {27'h503213F, 32'h78CA4488, 32'h3F1A3B81, 32'h62F188E5,
    32'h53CD265F, 32'h23C1567A, 32'h16876913, 32'hB0C2AC24, 32'h58492836};
  localparam logic [282:0] Gy = {27'h1CCDA38, 32'h0F1C9E31, 32'h8D90F95D, 32'h07E5426F,
    32'hE87E45C0, 32'hE8184698, 32'hE4596236, 32'h4E341161, 32'h77DD2259};
  localparam logic [282:0] Salt = {27'h5A5A5A5, {8{32'hC3A50F96}}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;
  logic         err;
  logic         pm_clr;
  logic         pm_start;
  logic [282:0] pm_d;
  logic         pm_done;
  logic [282:0] pm_x = '0;
  logic [282:0] pm_y = '0;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   start_cnt = 0;
  logic rdy_random = 1'b0;
  logic force_en = 1'b0;
  logic force_val = 1'b0;

  sect283k1_pt_mul_host #(.TimeoutCycles(TbTimeout)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .err      (err),
    .pm_clr   (pm_clr),
    .pm_start (pm_start),
    .pm_d     (pm_d),
    .pm_done  (pm_done),
    .pm_x     (pm_x),
    .pm_y     (pm_y)
  );

  always #5 clk = ~clk;

  function automatic logic [282:0] core_x(input logic [282:0] d);
    return (d == 283'd1) ? Gx : (d ^ Salt);
  endfunction

  function automatic logic [282:0] core_y(input logic [282:0] d);
    return (d == 283'd1) ? Gy : {d[281:0], d[282]};
  endfunction

  // Core model: done stays high until the next start or clr.
  logic         core_done = 1'b0;
  logic         core_busy = 1'b0;
  int           core_cnt = 0;
  logic [282:0] core_d = '0;
  assign pm_done = force_en ? force_val : core_done;

  always @(posedge clk) begin
    if (rst || pm_clr) begin
      core_done <= 1'b0;
      core_busy <= 1'b0;
      core_cnt  <= 0;
    end else if (pm_start) begin
      core_done <= 1'b0;
      core_busy <= 1'b1;
      core_cnt  <= CoreLat;
      core_d    <= pm_d;
    end else if (core_busy) begin
      if (core_cnt == 0) begin
        core_done <= 1'b1;
        core_busy <= 1'b0;
        pm_x      <= core_x(core_d);
        pm_y      <= core_y(core_d);
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  // Sink ready pattern, changed just after each active edge.
  always @(posedge clk) begin
    #1;
    out_ready = rdy_random ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  // Output monitor: scoreboard pops, stall stability, no input accept in SEND.
  logic        stall_q = 1'b0;
  logic [31:0] stall_data = '0;
  logic        stall_last = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (pm_start) start_cnt++;
      if (out_valid) begin
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL in_ready_in_send: got %b want 0", in_ready);
        else n_pass++;
      end
      if (stall_q) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== stall_data || out_last !== stall_last)
          $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   out_valid, out_data, out_last, stall_data, stall_last);
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_word: got d=%h l=%b want no output", out_data, out_last);
        end else begin
          mon_e = sb.pop_front();
          if (out_data !== mon_e.data || out_last !== mon_e.last)
            $display("FAIL result_word: got d=%h l=%b want d=%h l=%b",
                     out_data, out_last, mon_e.data, mon_e.last);
          else n_pass++;
        end
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_result(input logic [282:0] d);
    logic [287:0] xe;
    logic [287:0] ye;
    exp_t e;
    xe = {5'b0, core_x(d)};
    ye = {5'b0, core_y(d)};
    for (int k = 0; k < 18; k++) begin
      e.data = (k < 9) ? xe[k*32 +: 32] : ye[(k-9)*32 +: 32];
      e.last = (k == 17);
      sb.push_back(e);
    end
  endtask

  task automatic load_word(input logic [31:0] w);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 2000) begin
      tick();
      guard++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL load_wait: got in_ready=%b want 1 within 2000 cycles", in_ready);
    end
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_scalar(input logic [287:0] raw, input bit push, input int nwords);
    if (push) push_result(raw[282:0]);
    for (int k = 0; k < nwords; k++) load_word(raw[k*32 +: 32]);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
           && guard < 3000) begin
      tick();
      guard++;
    end
    n_checks++;
    if (guard >= 3000) $display("FAIL wait_idle: got %0d words pending want 0", sb.size());
    else n_pass++;
  endtask

  function automatic logic [287:0] rand_raw();
    logic [287:0] r;
    for (int k = 0; k < 9; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    clr = 1'b1;
    repeat (3) tick();
    n_checks += 9;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    if (out_data !== 32'h0) $display("FAIL rst_out_data: got %h want 0", out_data); else n_pass++;
    if (out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", out_last); else n_pass++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
    if (pm_clr !== 1'b0) $display("FAIL rst_pm_clr: got %b want 0", pm_clr); else n_pass++;
    if (pm_start !== 1'b0) $display("FAIL rst_pm_start: got %b want 0", pm_start); else n_pass++;
    if (pm_d !== 283'd0) $display("FAIL rst_pm_d: got %h want 0", pm_d); else n_pass++;
    rst = 1'b0;
    clr = 1'b0;
    tick();
    n_checks++;
    if (pm_clr !== 1'b0) $display("FAIL rst_no_clr_pulse: got %b want 0", pm_clr); else n_pass++;
  endtask

  task automatic test_generator();
    start_cnt = 0;
    load_scalar(288'd1, 1'b1, 9);
    wait_idle();
    n_checks += 2;
    if (start_cnt != 1) $display("FAIL gen_start_once: got %0d want 1", start_cnt); else n_pass++;
    if (pm_d !== 283'd1) $display("FAIL gen_pm_d_hold: got %h want 1", pm_d); else n_pass++;
  endtask

  task automatic test_word8_mask();
    logic [287:0] raw;
    raw = {32'hFFFFFFFF, 256'h0};
    load_scalar(raw, 1'b1, 9);
    n_checks += 2;
    if (pm_start !== 1'b1) $display("FAIL mask_start: got %b want 1", pm_start); else n_pass++;
    if (pm_d !== {27'h7FFFFFF, 256'h0})
      $display("FAIL mask_pm_d: got %h want %h", pm_d, {27'h7FFFFFF, 256'h0});
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_backpressure();
    rdy_random = 1'b1;
    load_scalar(rand_raw(), 1'b1, 9);
    wait_idle();
    rdy_random = 1'b0;
  endtask

  task automatic abort_pulse(input string tag);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    n_checks += 3;
    if (pm_clr !== 1'b1) $display("FAIL %s_pm_clr: got %b want 1", tag, pm_clr); else n_pass++;
    if (in_ready !== 1'b1) $display("FAIL %s_in_ready: got %b want 1", tag, in_ready); else n_pass++;
    tick();
    if (pm_clr !== 1'b0) $display("FAIL %s_pm_clr_once: got %b want 0", tag, pm_clr); else n_pass++;
  endtask

  task automatic test_abort_load();
    load_scalar(rand_raw(), 1'b0, 4);
    abort_pulse("abort_load");
    load_scalar(288'd1, 1'b1, 9);
    wait_idle();
  endtask

  task automatic test_abort_wait();
    load_scalar(rand_raw(), 1'b0, 9);
    repeat (10) tick();
    abort_pulse("abort_wait");
    repeat (60) tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL abort_wait_idle: got busy=%b want 0", busy); else n_pass++;
    load_scalar(288'd1, 1'b1, 9);
    wait_idle();
  endtask

  task automatic test_done_filter();
    force_en  = 1'b1;
    force_val = 1'b1;
    load_scalar(rand_raw(), 1'b1, 9);
    repeat (CoreLat + 20) tick();
    n_checks += 2;
    if (out_valid !== 1'b0) $display("FAIL filt_no_capture: got %b want 0", out_valid); else n_pass++;
    if (busy !== 1'b1) $display("FAIL filt_still_wait: got %b want 1", busy); else n_pass++;
    force_val = 1'b0;
    repeat (2) tick();
    force_en = 1'b0;
    wait_idle();
    // Done edge while in LOAD must be ignored.
    force_en  = 1'b1;
    force_val = 1'b0;
    tick();
    force_val = 1'b1;
    tick();
    force_en = 1'b0;
    repeat (20) tick();
    n_checks += 2;
    if (busy !== 1'b0) $display("FAIL filt_load_edge_busy: got %b want 0", busy); else n_pass++;
    if (in_ready !== 1'b1) $display("FAIL filt_load_edge_ready: got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int guard;
    load_scalar(rand_raw(), 1'b1, 9);
    guard = 0;
    while (in_ready !== 1'b1 && guard < 2000) begin
      tick();
      guard++;
    end
    n_checks++;
    if (sb.size() != 0) $display("FAIL b2b_no_overlap: got %0d pending want 0", sb.size());
    else n_pass++;
    load_scalar(rand_raw(), 1'b1, 9);
    wait_idle();
  endtask

`ifdef PT_MUL_TIMEOUT_EN
  task automatic test_timeout();
    int waits;
    force_en  = 1'b1;
    force_val = 1'b0;
    load_scalar(rand_raw(), 1'b0, 9);
    tick();
    waits = 0;
    while (busy === 1'b1 && waits < 500) begin
      waits++;
      tick();
    end
    n_checks += 6;
    if (waits != 100) $display("FAIL tmo_cycles: got %0d want 100", waits); else n_pass++;
    if (err !== 1'b1) $display("FAIL tmo_err: got %b want 1", err); else n_pass++;
    if (pm_clr !== 1'b1) $display("FAIL tmo_pm_clr: got %b want 1", pm_clr); else n_pass++;
    if (in_ready !== 1'b1) $display("FAIL tmo_in_ready: got %b want 1", in_ready); else n_pass++;
    tick();
    if (pm_clr !== 1'b0) $display("FAIL tmo_pm_clr_once: got %b want 0", pm_clr); else n_pass++;
    if (err !== 1'b1) $display("FAIL tmo_err_sticky: got %b want 1", err); else n_pass++;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if (err !== 1'b0) $display("FAIL tmo_err_clr: got %b want 0", err); else n_pass++;
    tick();
    force_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_generator();
    test_word8_mask();
    test_backpressure();
    test_abort_load();
    test_abort_wait();
    test_done_filter();
    test_back_to_back();
`ifdef PT_MUL_TIMEOUT_EN
    test_timeout();
`endif
    repeat (5) tick();
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_drained: got %0d pending want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion want finish before 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
